rpn_stack_calc: RTL and testbench

Parametrised reverse-Polish calculator core. It replaces the fixed A/B/OP entry sequence with an operand stack of DEPTH entries, each WIDTH bits wide. Operands are pushed from the switches; operations pop their operands, compute, and push the result. It sits between the debounced button/switch inputs and the display register. TOP and SECOND feed the display, and the error flags drive the RGB LED.

---
 rtl/rpn_pkg.sv | 26 ++
 rtl/rpn_alu.sv | 48 ++++
 rtl/rpn_stack_calc.sv | 161 ++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator core.
// Opcode encoding, FSM states and operand-count helper.
package rpn_pkg;

    typedef enum logic [2:0] {
        ADD,
        SUB,
        MUL,
        AND_OP,
        OR_OP,
        DUP,
        SWAP,
        DROP
    } op_t;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    // DUP and DROP touch only the top entry; everything else needs two.
    function automatic int op_arity(op_t op);
        return (op == DUP || op == DROP) ? 1 : 2;
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN core.
// A is the second entry, B is the top entry.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  op_t              OP,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};
    assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Select result and carry/borrow/truncation flag by opcode.
    always_comb begin
        RESULT = '0;
        CARRY  = 1'b0;
        unique case (OP)
            ADD: begin
                RESULT = sum[WIDTH-1:0];
                CARRY  = sum[WIDTH];
            end
            SUB: begin
                RESULT = diff[WIDTH-1:0];
                CARRY  = diff[WIDTH];
            end
            MUL: begin
                RESULT = prod[WIDTH-1:0];
                CARRY  = |prod[2*WIDTH-1:WIDTH];
            end
            AND_OP: RESULT = A & B;
            OR_OP:  RESULT = A | B;
            DUP:    RESULT = B;
            SWAP:   RESULT = B;
            DROP:   RESULT = B;
        endcase
    end

endmodule

// File: rtl/rpn_stack_calc.sv
// Reverse-Polish calculator core with a DEPTH-entry operand stack.
// Entry 0 is the top; entries at index >= COUNT are kept at zero.
module rpn_stack_calc
    import rpn_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             PUSH,
    input  logic             EXEC,
    input  op_t              OP,
    input  logic             CLEAR,
    output logic [WIDTH-1:0] TOP,
    output logic [WIDTH-1:0] SECOND,
    output logic [CW-1:0]    COUNT,
    output logic             BUSY,
    output logic             ERR_UNDERFLOW,
    output logic             ERR_OVERFLOW,
    output logic             ERR_CARRY
);

    state_t                       state, state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]  stk, stk_nxt;
    logic [CW-1:0]                count, count_nxt;
    logic [WIDTH-1:0]             a_q, a_nxt;
    logic [WIDTH-1:0]             b_q, b_nxt;
    op_t                          op_q, op_nxt;
    logic                         uf, uf_nxt;
    logic                         of, of_nxt;
    logic                         cy, cy_nxt;
    logic [WIDTH-1:0]             alu_res;
    logic                         alu_cy;
    logic                         full;

    assign full = (count == CW'(DEPTH));

    rpn_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .A      (a_q),
        .B      (b_q),
        .OP     (op_q),
        .RESULT (alu_res),
        .CARRY  (alu_cy)
    );

    // Next-state, stack update and flag logic for both FSM states.
    always_comb begin
        state_nxt = state;
        stk_nxt   = stk;
        count_nxt = count;
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        uf_nxt    = uf;
        of_nxt    = of;
        cy_nxt    = cy;
        unique case (state)
            IDLE: begin
                if (CLEAR) begin
                    stk_nxt   = '0;
                    count_nxt = '0;
                    {uf_nxt, of_nxt, cy_nxt} = 3'b000;
                end else if (PUSH) begin
                    if (full) begin
                        {uf_nxt, of_nxt, cy_nxt} = 3'b010;
                    end else begin
                        for (int i = DEPTH - 1; i > 0; i--)
                            stk_nxt[i] = stk[i-1];
                        stk_nxt[0] = DATA_IN;
                        count_nxt  = count + CW'(1);
                        {uf_nxt, of_nxt, cy_nxt} = 3'b000;
                    end
                end else if (EXEC) begin
                    if (int'(count) < op_arity(OP)) begin
                        {uf_nxt, of_nxt, cy_nxt} = 3'b100;
                    end else if (OP == DUP && full) begin
                        {uf_nxt, of_nxt, cy_nxt} = 3'b010;
                    end else begin
                        a_nxt     = stk[1];
                        b_nxt     = stk[0];
                        op_nxt    = OP;
                        state_nxt = CALC;
                        {uf_nxt, of_nxt, cy_nxt} = 3'b000;
                    end
                end
            end
            CALC: begin
                state_nxt = IDLE;
                unique case (op_q)
                    DUP: begin
                        for (int i = DEPTH - 1; i > 0; i--)
                            stk_nxt[i] = stk[i-1];
                        stk_nxt[0] = b_q;
                        count_nxt  = count + CW'(1);
                    end
                    SWAP: begin
                        stk_nxt[0] = a_q;
                        stk_nxt[1] = b_q;
                    end
                    DROP: begin
                        for (int i = 0; i < DEPTH - 1; i++)
                            stk_nxt[i] = stk[i+1];
                        stk_nxt[DEPTH-1] = '0;
                        count_nxt = count - CW'(1);
                    end
                    default: begin
                        for (int i = 0; i < DEPTH - 1; i++)
                            stk_nxt[i] = stk[i+1];
                        stk_nxt[DEPTH-1] = '0;
                        stk_nxt[0] = alu_res;
                        count_nxt  = count - CW'(1);
                        cy_nxt     = alu_cy;
                    end
                endcase
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Stack, operand latches and flag registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stk   <= '0;
            count <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= ADD;
            uf    <= 1'b0;
            of    <= 1'b0;
            cy    <= 1'b0;
        end else begin
            stk   <= stk_nxt;
            count <= count_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            op_q  <= op_nxt;
            uf    <= uf_nxt;
            of    <= of_nxt;
            cy    <= cy_nxt;
        end
    end

    assign TOP           = stk[0];
    assign SECOND        = stk[1];
    assign COUNT         = count;
    assign BUSY          = (state == CALC);
    assign ERR_UNDERFLOW = uf;
    assign ERR_OVERFLOW  = of;
    assign ERR_CARRY     = cy;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Bench for rpn_stack_calc: 16x4 and 8x8 instances share stimulus.
// Each is checked every cycle against a list-based stack model.
module tb_rpn_stack_calc;
    import rpn_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        push = 1'b0;
    logic        exec = 1'b0;
    logic        clear = 1'b0;
    op_t         op = ADD;
    bit          cmp_en = 1'b0;

    logic [15:0] top16, sec16;
    logic [2:0]  cnt16;
    logic        busy16, uf16, of16, cy16;
    logic [7:0]  top8, sec8;
    logic [3:0]  cnt8;
    logic        busy8, uf8, of8, cy8;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rpn_stack_calc #(.WIDTH(16), .DEPTH(4)) dut16 (
        .CLK(clk), .RESET(rst), .DATA_IN(din), .PUSH(push),
        .EXEC(exec), .OP(op), .CLEAR(clear),
        .TOP(top16), .SECOND(sec16), .COUNT(cnt16), .BUSY(busy16),
        .ERR_UNDERFLOW(uf16), .ERR_OVERFLOW(of16), .ERR_CARRY(cy16)
    );

    rpn_stack_calc #(.WIDTH(8), .DEPTH(8)) dut8 (
        .CLK(clk), .RESET(rst), .DATA_IN(din[7:0]), .PUSH(push),
        .EXEC(exec), .OP(op), .CLEAR(clear),
        .TOP(top8), .SECOND(sec8), .COUNT(cnt8), .BUSY(busy8),
        .ERR_UNDERFLOW(uf8), .ERR_OVERFLOW(of8), .ERR_CARRY(cy8)
    );

    // ---------------- behavioural model ----------------
    longint ms[2][8];
    int     mcnt[2];
    bit     mbusy[2];
    op_t    mop[2];
    bit     muf[2], mof[2], mcy[2];

    function automatic void chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic void mreset(int k);
        for (int i = 0; i < 8; i++) ms[k][i] = 0;
        mcnt[k] = 0; mbusy[k] = 0; mop[k] = ADD;
        muf[k] = 0; mof[k] = 0; mcy[k] = 0;
    endfunction

    function automatic void mpush(int k, longint v);
        for (int i = 7; i > 0; i--) ms[k][i] = ms[k][i-1];
        ms[k][0] = v;
        mcnt[k]++;
    endfunction

    function automatic longint mpop(int k);
        longint v = ms[k][0];
        for (int i = 0; i < 7; i++) ms[k][i] = ms[k][i+1];
        ms[k][7] = 0;
        mcnt[k]--;
        return v;
    endfunction

    function automatic void mflags(int k, bit u, bit o, bit c);
        muf[k] = u; mof[k] = o; mcy[k] = c;
    endfunction

    function automatic void mstep(int k, int w, int d, bit c_i, bit p_i,
                                  bit e_i, op_t o_i, longint d_i);
        longint m = (longint'(1) << w) - 1;
        longint a, b, r;
        int need;
        if (mbusy[k]) begin
            mbusy[k] = 0;
            case (mop[k])
                DUP:  mpush(k, ms[k][0]);
                SWAP: begin
                    a = ms[k][1]; ms[k][1] = ms[k][0]; ms[k][0] = a;
                end
                DROP: void'(mpop(k));
                default: begin
                    b = mpop(k);
                    a = mpop(k);
                    r = 0;
                    case (mop[k])
                        ADD:    begin r = a + b; mcy[k] = (r > m); end
                        SUB:    begin r = a - b; mcy[k] = (a < b); end
                        MUL:    begin r = a * b; mcy[k] = (r > m); end
                        AND_OP: r = a & b;
                        OR_OP:  r = a | b;
                        default: r = 0;
                    endcase
                    mpush(k, r & m);
                end
            endcase
        end else if (c_i) begin
            for (int i = 0; i < 8; i++) ms[k][i] = 0;
            mcnt[k] = 0;
            mflags(k, 0, 0, 0);
        end else if (p_i) begin
            if (mcnt[k] < d) begin
                mpush(k, d_i & m);
                mflags(k, 0, 0, 0);
            end else mflags(k, 0, 1, 0);
        end else if (e_i) begin
            need = (o_i == DUP || o_i == DROP) ? 1 : 2;
            if (mcnt[k] < need) mflags(k, 1, 0, 0);
            else if (o_i == DUP && mcnt[k] == d) mflags(k, 0, 1, 0);
            else begin
                mflags(k, 0, 0, 0);
                mbusy[k] = 1;
                mop[k] = o_i;
            end
        end
    endfunction

    function automatic longint mtop(int k);
        return (mcnt[k] > 0) ? ms[k][0] : 0;
    endfunction

    function automatic longint msec(int k);
        return (mcnt[k] > 1) ? ms[k][1] : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, 16, 4, clear, push, exec, op, longint'(din));
            mstep(1, 8, 8, clear, push, exec, op, longint'(din));
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("m16.top",  top16,  mtop(0));
            chk("m16.sec",  sec16,  msec(0));
            chk("m16.cnt",  cnt16,  mcnt[0]);
            chk("m16.busy", busy16, mbusy[0]);
            chk("m16.uf",   uf16,   muf[0]);
            chk("m16.of",   of16,   mof[0]);
            chk("m16.cy",   cy16,   mcy[0]);
            chk("m8.top",   top8,   mtop(1));
            chk("m8.sec",   sec8,   msec(1));
            chk("m8.cnt",   cnt8,   mcnt[1]);
            chk("m8.busy",  busy8,  mbusy[1]);
            chk("m8.uf",    uf8,    muf[1]);
            chk("m8.of",    of8,    mof[1]);
            chk("m8.cy",    cy8,    mcy[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_push(logic [15:0] v);
        push = 1'b1; din = v;
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_exec(op_t o, bit busy_exp);
        exec = 1'b1; op = o;
        @(negedge clk);
        exec = 1'b0;
        chk("busy16.calc", busy16, busy_exp);
        @(negedge clk);
        chk("busy16.done", busy16, 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst.top",  top16, 0);
        chk("rst.cnt",  cnt16, 0);
        chk("rst.busy", busy16, 0);
        chk("rst.fl",   {uf16, of16, cy16}, 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // 3 + 5
        do_push(16'h0003);
        do_push(16'h0005);
        do_exec(ADD, 1);
        chk("add.top16", top16, 16'h0008);
        chk("add.top8",  top8,  8'h08);
        chk("add.cnt",   cnt16, 1);
        chk("add.fl",    {uf16, of16, cy16}, 0);

        // underflow then recovery
        do_exec(SUB, 0);
        chk("uf.flag", uf16, 1);
        chk("uf.top",  top16, 16'h0008);
        chk("uf.cnt",  cnt16, 1);
        do_push(16'h0001);
        chk("uf.clr",  uf16, 0);

        // overflow at DEPTH
        do_clear();
        for (int i = 1; i <= 5; i++) do_push(16'(i));
        chk("of.flag", of16, 1);
        chk("of.cnt",  cnt16, 4);
        chk("of.top",  top16, 16'h0004);
        chk("of8.cnt", cnt8, 5);
        do_exec(DUP, 0);
        chk("dup.of",  of16, 1);
        chk("dup.cnt", cnt16, 4);
        chk("dup.top", top16, 16'h0004);

        // carry / borrow / truncation
        do_clear();
        do_push(16'hFFFF);
        do_push(16'h0002);
        do_exec(ADD, 1);
        chk("cy.add.top",  top16, 16'h0001);
        chk("cy.add.cy",   cy16, 1);
        chk("cy.add8.top", top8, 8'h01);
        chk("cy.add8.cy",  cy8, 1);
        do_clear();
        do_push(16'h0003);
        do_push(16'h0005);
        do_exec(SUB, 1);
        chk("sub.top",  top16, 16'hFFFE);
        chk("sub.cy",   cy16, 1);
        chk("sub8.top", top8, 8'hFE);
        do_clear();
        do_push(16'h0100);
        do_push(16'h0100);
        do_exec(MUL, 1);
        chk("mul.top", top16, 16'h0000);
        chk("mul.cy",  cy16, 1);

        // swap, drop, push/exec collision
        do_clear();
        do_push(16'h00AA);
        do_push(16'h0055);
        do_exec(SWAP, 1);
        chk("swap.top", top16, 16'h00AA);
        chk("swap.sec", sec16, 16'h0055);
        do_exec(DROP, 1);
        chk("drop.cnt", cnt16, 1);
        chk("drop.top", top16, 16'h0055);
        chk("drop.sec", sec16, 0);
        push = 1'b1; exec = 1'b1; din = 16'h0007; op = AND_OP;
        @(negedge clk);
        push = 1'b0; exec = 1'b0;
        chk("coll.busy", busy16, 0);
        chk("coll.cnt",  cnt16, 2);
        chk("coll.top",  top16, 16'h0007);

        // asynchronous reset in CALC
        do_push(16'h0009);
        exec = 1'b1; op = ADD;
        @(negedge clk);
        exec = 1'b0;
        chk("ar.busy_pre", busy16, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar.top",  top16, 0);
        chk("ar.sec",  sec16, 0);
        chk("ar.cnt",  cnt16, 0);
        chk("ar.busy", busy16, 0);
        chk("ar.fl",   {uf16, of16, cy16}, 0);
        chk("ar.top8", top8, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        do_push(16'h1234);
        chk("ar.push.top", top16, 16'h1234);
        chk("ar.push.cnt", cnt16, 1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            clear = ($urandom_range(0, 31) == 0);
            push  = ($urandom_range(0, 2) == 0);
            exec  = ($urandom_range(0, 1) == 0);
            op    = op_t'($urandom_range(0, 7));
            din   = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                                 : 16'($urandom);
            @(negedge clk);
        end
        clear = 1'b0; push = 1'b0; exec = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
